// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the DE2 SRAM arbiter slice.
package sram_arb_pkg;

  localparam int unsigned ADDR_W_DEF     = 18;
  localparam int unsigned DATA_W_DEF     = 16;
  localparam int unsigned STARVE_MAX_DEF = 8;
  localparam int unsigned ACC_CYCLES     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_VID  = 2'd1,
    GNT_CPU  = 2'd2
  } grant_t;

  // Pin phase the PHY presents during the next cycle.
  typedef enum logic [1:0] {
    PH_IDLE      = 2'd0,
    PH_READ      = 2'd1,
    PH_WR_STROBE = 2'd2,
    PH_WR_HOLD   = 2'd3
  } phase_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sram_de2_phy.sv
// Pin-side registers for the DE2 async SRAM: strobes, address, DQ tristate
// and read-data capture. Every pin is driven straight from a flop.
module sram_de2_phy
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  phase_t            phase_nxt,
  input  logic              load,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [1:0]        be_in,
  input  logic              cap_en,
  output logic [DATA_W-1:0] cap_data,
  output logic              cap_valid,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_dq,
  output logic              we_n,
  output logic              oe_n,
  output logic              ub_n,
  output logic              lb_n,
  output logic              ce_n
);

  logic [DATA_W-1:0] dq_out;
  logic              dq_oe;

  assign sram_dq = dq_oe ? dq_out : 'z;

  // Register the pin image for the coming cycle; capture DQ on request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_addr <= '0;
      dq_out    <= '0;
      dq_oe     <= 1'b0;
      we_n      <= 1'b1;
      oe_n      <= 1'b1;
      ub_n      <= 1'b1;
      lb_n      <= 1'b1;
      ce_n      <= 1'b1;
      cap_data  <= '0;
      cap_valid <= 1'b0;
    end else begin
      if (load) begin
        sram_addr <= addr_in;
        dq_out    <= wdata_in;
      end
      case (phase_nxt)
        PH_READ: begin
          ce_n  <= 1'b0;
          oe_n  <= 1'b0;
          we_n  <= 1'b1;
          ub_n  <= 1'b0;
          lb_n  <= 1'b0;
          dq_oe <= 1'b0;
        end
        PH_WR_STROBE: begin
          // Only ever entered on a load, so be_in belongs to this access.
          ce_n  <= 1'b0;
          oe_n  <= 1'b1;
          we_n  <= 1'b0;
          ub_n  <= ~be_in[1];
          lb_n  <= ~be_in[0];
          dq_oe <= 1'b1;
        end
        PH_WR_HOLD: begin
          // Byte strobes keep their strobe-phase values; data held driven.
          ce_n  <= 1'b0;
          oe_n  <= 1'b1;
          we_n  <= 1'b1;
          dq_oe <= 1'b1;
        end
        default: begin
          ce_n  <= 1'b1;
          oe_n  <= 1'b1;
          we_n  <= 1'b1;
          ub_n  <= 1'b1;
          lb_n  <= 1'b1;
          dq_oe <= 1'b0;
        end
      endcase
      cap_valid <= cap_en;
      if (cap_en) cap_data <= sram_dq;
    end
  end

endmodule

// File: rtl/sram_de2_arbiter.sv
// Two-port arbiter for the DE2 256Kx16 async SRAM. Port V (video reads)
// has priority; port C (CPU read/write) is guaranteed a grant after
// STARVE_MAX consecutive V grants. Optional grant statistics are built
// when SRAM_ARB_STATS_EN is defined.
module sram_de2_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [1:0]        cpu_be,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] sram_de2_ADDR,
  inout  wire  [DATA_W-1:0] sram_de2_DQ,
  output logic              sram_de2_WE_N,
  output logic              sram_de2_OE_N,
  output logic              sram_de2_UB_N,
  output logic              sram_de2_LB_N,
  output logic              sram_de2_CE_N
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_vid_grants,
  output logic [15:0]       stat_cpu_grants,
  output logic [15:0]       stat_conflicts
`endif
);

  state_t            state;
  grant_t            gnt_q;
  grant_t            cap_gnt;
  grant_t            win;
  logic              we_q;
  logic [7:0]        starve_cnt;
  logic              decision;
  logic              starve_hit;
  phase_t            phase_nxt;
  logic              load;
  logic [ADDR_W-1:0] addr_in;
  logic              cap_en;
  logic [DATA_W-1:0] cap_data;
  logic              cap_valid;

  assign decision   = (state == IDLE) || (state == ACC2);
  assign starve_hit = (32'(starve_cnt) == STARVE_MAX);
  assign load       = (win != GNT_NONE);
  assign cap_en     = (state == ACC2) && !we_q;

  // Pick the winner at a decision edge and the pin phase for the next cycle.
  always_comb begin
    win       = GNT_NONE;
    phase_nxt = PH_IDLE;
    addr_in   = vid_addr;
    if (decision) begin
      if (cpu_req && (!vid_req || starve_hit)) begin
        win       = GNT_CPU;
        addr_in   = cpu_addr;
        phase_nxt = cpu_we ? PH_WR_STROBE : PH_READ;
      end else if (vid_req) begin
        win       = GNT_VID;
        phase_nxt = PH_READ;
      end
    end else if (state == ACC1) begin
      phase_nxt = we_q ? PH_WR_HOLD : PH_READ;
    end
  end

  // Access sequencer, starvation counter, acks and read return stage.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state      <= IDLE;
      gnt_q      <= GNT_NONE;
      cap_gnt    <= GNT_NONE;
      we_q       <= 1'b0;
      starve_cnt <= '0;
      vid_ack    <= 1'b0;
      cpu_ack    <= 1'b0;
      vid_rvalid <= 1'b0;
      cpu_rvalid <= 1'b0;
      vid_rdata  <= '0;
      cpu_rdata  <= '0;
    end else begin
      if (decision) begin
        state <= load ? ACC1 : IDLE;
        if (load) begin
          gnt_q <= win;
          we_q  <= (win == GNT_CPU) && cpu_we;
        end
        if (!cpu_req || win == GNT_CPU) starve_cnt <= '0;
        else if (win == GNT_VID)        starve_cnt <= sat_inc8(starve_cnt);
      end else begin
        state <= ACC2;
      end
      vid_ack <= (win == GNT_VID);
      cpu_ack <= (win == GNT_CPU);
      if (cap_en) cap_gnt <= gnt_q;
      vid_rvalid <= cap_valid && (cap_gnt == GNT_VID);
      cpu_rvalid <= cap_valid && (cap_gnt == GNT_CPU);
      if (cap_valid && cap_gnt == GNT_VID) vid_rdata <= cap_data;
      if (cap_valid && cap_gnt == GNT_CPU) cpu_rdata <= cap_data;
    end
  end

`ifdef SRAM_ARB_STATS_EN
  // Saturating grant and conflict counters.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      stat_vid_grants <= '0;
      stat_cpu_grants <= '0;
      stat_conflicts  <= '0;
    end else begin
      if (win == GNT_VID) stat_vid_grants <= sat_inc16(stat_vid_grants);
      if (win == GNT_CPU) stat_cpu_grants <= sat_inc16(stat_cpu_grants);
      if (decision && vid_req && cpu_req) stat_conflicts <= sat_inc16(stat_conflicts);
    end
  end
`endif

  sram_de2_phy #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_phy (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .phase_nxt (phase_nxt),
    .load      (load),
    .addr_in   (addr_in),
    .wdata_in  (cpu_wdata),
    .be_in     (cpu_be),
    .cap_en    (cap_en),
    .cap_data  (cap_data),
    .cap_valid (cap_valid),
    .sram_addr (sram_de2_ADDR),
    .sram_dq   (sram_de2_DQ),
    .we_n      (sram_de2_WE_N),
    .oe_n      (sram_de2_OE_N),
    .ub_n      (sram_de2_UB_N),
    .lb_n      (sram_de2_LB_N),
    .ce_n      (sram_de2_CE_N)
  );

endmodule
